skid_pipe_reg: RTL and testbench
================================

# skid_pipe_reg

- Parametrised pipeline stage register for the pipelined MIPS datapath. It replaces plain enable-registers between stages with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble (NOP) insertion.
- Full throughput: one transfer per cycle with registered `in_ready`, so back-pressure never forms a combinational path across stages.
- One instance sits at each of IF/ID, ID/EX, EX/MEM and MEM/WB.

## Interface
- `bREG`, 32: payload width in bits; must be ≥ 1.
- `NOP_VALUE`, 0: value driven on `out_data` whenever the stage holds nothing (a bubble).
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; asserted at 0.
- `flush` input 1: synchronous kill of all held entries.
- `in_valid` input 1: upstream presents `in_data`.
- `in_data` input `bREG`: payload from upstream.
- `in_ready` output 1: stage accepts `in_data` this cycle.
- `out_valid` output 1: `out_data` holds a real entry.
- `out_data` output `bREG`: head entry, or `NOP_VALUE` when empty.
- `out_ready` input 1: downstream consumes the head this cycle.
- `occupancy` output 2: entries held (0, 1 or 2).

## Operation
- Two entries:
  - main: drives `out_data`/`out_valid`.
  - skid: holds one entry when the head is stalled.
- Handshake terms: in-fire = `in_valid & in_ready`; out-fire = `out_valid & out_ready`.
- `in_ready` = `!skid_valid & !flush`. It depends on `flush` combinationally and on nothing else combinationally.
- `out_valid` never depends combinationally on `out_ready`.
- Upstream must hold `in_data` stable while `in_valid & !in_ready`. Violations are not checked.
- Next-state rules, evaluated in priority order:
  - `flush`=1: main and skid are emptied and `out_data` <= `NOP_VALUE`. The input is dropped (`in_ready`=0) and any out-fire that cycle still counts downstream.
  - Main empty: in-fire loads main.
  - Main full, skid empty, out-fire: in-fire loads main with the new data; with no in-fire, main empties and `out_data` <= `NOP_VALUE`.
  - Main full, skid empty, no out-fire: in-fire loads skid.
  - Skid full (`in_ready`=0): out-fire moves skid to main and empties skid. Otherwise hold.
- Ordering is strictly FIFO: the skid entry is always older than any later input.
- `occupancy` = `main_valid + skid_valid`, registered with the entries.
- Reset values: `out_valid`=0, `out_data`=`NOP_VALUE`, skid empty, `in_ready`=1 (when `flush`=0), `occupancy`=0.

## Timing
- Latency: 1 cycle. Data accepted at edge N appears on `out_data` after edge N, i.e. in cycle N+1.
- Sustained throughput: 1 entry/cycle while `out_ready`=1.
- `in_ready` falls in the cycle after the skid fills. It rises in the cycle after the skid drains.
- Reset assertion clears all state immediately, independent of `clock`. Deassertion is synchronised externally; the first accepted input is on the first edge after release.
- Reset in mid-stall drops both entries with no partial output.
- Simultaneous in-fire and out-fire with occupancy 1 leaves occupancy at 1.

## Structure
- Shared package `mips_ppl_pkg`:
  - `NOP_WORD` constant (32'h0000_0000, `sll $0,$0,0`), used as the default for `NOP_VALUE`.
  - Default stage widths: `IFID_W`, `IDEX_W`, `EXMEM_W`, `MEMWB_W`.
- One natural sub-module, `stage_entry`: a `bREG`-wide data register plus valid bit, with load/clear enables, async active-low reset and reset value `NOP_VALUE`. Instantiate it twice, for main and skid.
- Control logic stays in `skid_pipe_reg`.

## Test plan
- Reset and stream:
  - Stimulus: hold `reset`=0, then release and drive `in_data`=1,2,3,4 on consecutive cycles with `out_ready`=1.
  - Required response: during reset `out_data`=`NOP_VALUE`, `out_valid`=0, `occupancy`=0. After release `out_data`=1,2,3,4 one cycle later, no gaps, `in_ready` stays 1.
- Stall fill:
  - Stimulus: `out_ready`=0 while sending 0xA then 0xB.
  - Required response: `occupancy`=2 and `in_ready`=0; 0xC is held upstream. On `out_ready`=1 the output is 0xA, 0xB, 0xC in order, with no loss or duplication.
- Flush:
  - Stimulus: with `occupancy`=2, assert `flush` together with `in_valid` (0xD).
  - Required response: next cycle `occupancy`=0, `out_valid`=0, `out_data`=`NOP_VALUE`; 0xD is not accepted.
- Bubble:
  - Stimulus: deliver a single entry 0x5 and consume it, with `in_valid`=0.
  - Required response: `out_data` returns to `NOP_VALUE`, `out_valid`=0.
- Async reset mid-stall:
  - Stimulus: pulse `reset` low between clock edges while `occupancy`=2.
  - Required response: outputs clear immediately, without waiting for an edge.
- Random back-pressure:
  - Stimulus: 1000 cycles of random `in_valid`/`out_ready` at `bREG`=8 and `bREG`=64.
  - Required response: the scoreboard matches FIFO order, and `occupancy` always equals the scoreboard depth.

Source files
------------

// File: rtl/mips_ppl_pkg.sv
// rtl/mips_ppl_pkg.sv - shared constants for the pipelined MIPS stage registers
// Purpose : NOP encoding used as the empty-stage value, default widths of the
//           four inter-stage registers, and the occupancy count type.
// Ports   : none (package)
package mips_ppl_pkg;

  // sll $0,$0,0 encodes as all zeros.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // IF/ID: pc + instruction
  localparam int IFID_W  = 64;
  // ID/EX: pc, rs/rt values, sign-extended immediate, rd/rt indices, control
  localparam int IDEX_W  = 32 * 4 + 5 * 2 + 12;
  // EX/MEM: alu result, store data, write register, control
  localparam int EXMEM_W = 32 * 2 + 5 + 6;
  // MEM/WB: load data, alu result, write register, control
  localparam int MEMWB_W = 32 * 2 + 5 + 2;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/stage_entry.sv
// rtl/stage_entry.sv - one pipeline entry: data register plus valid bit
// Purpose : holds a single payload; clear empties it and parks the data at
//           NOP_VALUE so an empty stage always presents a bubble.
// Ports   : clock, reset (async, active-low)
//           i_load  - capture i_data and mark valid
//           i_clear - empty the entry (wins over i_load)
//           i_data  - payload to capture
//           o_valid - entry holds a real payload
//           o_data  - held payload, NOP_VALUE when empty
module stage_entry #(
  parameter int              bREG      = 32,
  parameter logic [bREG-1:0] NOP_VALUE = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [bREG-1:0] i_data,
  output logic            o_valid,
  output logic [bREG-1:0] o_data
);

  logic            r_valid;
  logic [bREG-1:0] r_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VALUE;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= NOP_VALUE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/skid_pipe_reg.sv
// rtl/skid_pipe_reg.sv - valid/ready pipeline stage with 2-entry skid buffer
// Purpose : inter-stage register with full throughput, registered in_ready,
//           synchronous flush and NOP output when empty.
// Ports   : clock, reset (async, active-low)
//           flush               - drop both entries, refuse input this cycle
//           in_valid/in_data    - upstream payload
//           in_ready            - stage accepts in_data this cycle
//           out_valid/out_data  - head entry (NOP_VALUE when empty)
//           out_ready           - downstream consumes head this cycle
//           occupancy           - entries held (0..2)
module skid_pipe_reg
  import mips_ppl_pkg::*;
#(
  parameter int              bREG      = 32,
  parameter logic [bREG-1:0] NOP_VALUE = bREG'(NOP_WORD)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [bREG-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [bREG-1:0] out_data,
  input  logic            out_ready,
  output occ_t            occupancy
);

  logic            w_main_valid;
  logic [bREG-1:0] w_main_data;
  logic            w_skid_valid;
  logic [bREG-1:0] w_skid_data;

  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_main_load;
  logic            w_main_clear;
  logic [bREG-1:0] w_main_next;
  logic            w_skid_load;
  logic            w_skid_clear;

  // in_ready comes straight off the skid flop; flush is the only
  // combinational input, so back-pressure never chains across stages.
  assign in_ready   = !w_skid_valid && !flush;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = w_main_valid && out_ready;

  always_comb begin
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_main_next  = in_data;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    if (flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else if (!w_main_valid) begin
      w_main_load = w_in_fire;
    end else if (!w_skid_valid) begin
      if (w_out_fire) begin
        // head leaves: either replace it or fall back to a bubble
        w_main_load  = w_in_fire;
        w_main_clear = !w_in_fire;
      end else begin
        w_skid_load = w_in_fire;
      end
    end else if (w_out_fire) begin
      // skid is older than anything upstream, so it becomes the head
      w_main_load  = 1'b1;
      w_main_next  = w_skid_data;
      w_skid_clear = 1'b1;
    end
  end

  stage_entry #(.bREG(bREG), .NOP_VALUE(NOP_VALUE)) u_main (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_next),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  stage_entry #(.bREG(bREG), .NOP_VALUE(NOP_VALUE)) u_skid (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (in_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  // Both terms are flops, so occupancy changes only with the entries.
  assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule

// File: tb/tb_skid_pipe_reg.sv
// tb/tb_skid_pipe_reg.sv - testbench for skid_pipe_reg
module tb_skid_pipe_reg;

  localparam logic [7:0]  NOP8  = 8'hA5;
  localparam logic [63:0] NOP64 = 64'h0123_4567_89AB_CDEF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // 32-bit directed instance
  logic        fl, iv, ordy;
  logic [31:0] id;
  logic        ir, ov;
  logic [31:0] od;
  logic [1:0]  occ;

  skid_pipe_reg u_dut (
    .clock(clock), .reset(reset), .flush(fl), .in_valid(iv), .in_data(id),
    .in_ready(ir), .out_valid(ov), .out_data(od), .out_ready(ordy), .occupancy(occ)
  );

  // random instances: index 0 is 8-bit, index 1 is 64-bit
  logic        r_fl[2], r_iv[2], r_or[2];
  logic [63:0] r_d[2];
  logic        a_ir[2], a_ov[2];
  logic [63:0] a_od[2];
  logic [1:0]  a_occ[2];
  logic [7:0]  od8;
  logic [63:0] od64;

  skid_pipe_reg #(.bREG(8), .NOP_VALUE(NOP8)) u_dut8 (
    .clock(clock), .reset(reset), .flush(r_fl[0]), .in_valid(r_iv[0]), .in_data(r_d[0][7:0]),
    .in_ready(a_ir[0]), .out_valid(a_ov[0]), .out_data(od8), .out_ready(r_or[0]), .occupancy(a_occ[0])
  );

  skid_pipe_reg #(.bREG(64), .NOP_VALUE(NOP64)) u_dut64 (
    .clock(clock), .reset(reset), .flush(r_fl[1]), .in_valid(r_iv[1]), .in_data(r_d[1]),
    .in_ready(a_ir[1]), .out_valid(a_ov[1]), .out_data(od64), .out_ready(r_or[1]), .occupancy(a_occ[1])
  );

  assign a_od[0] = {56'b0, od8};
  assign a_od[1] = od64;

  typedef struct {
    logic        fl, iv, ordy;
    logic [31:0] d;
    logic        e_ov, e_ir;
    logic [31:0] e_od;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic f, input logic v, input logic [31:0] d, input logic r,
                     input logic eov, input logic [31:0] eod, input logic eir, input logic [1:0] eocc);
    vec_t t;
    t.fl = f; t.iv = v; t.d = d; t.ordy = r;
    t.e_ov = eov; t.e_od = eod; t.e_ir = eir; t.e_occ = eocc;
    vecs.push_back(t);
  endtask

  // random-test reference: a depth-2 FIFO per instance
  logic [63:0] mdat[2][2];
  int          mcnt[2];
  logic        hold[2];

  initial begin
    // stream 1..4, then bubble
    add(0,1,32'h1,1, 0,32'h0,1,0);
    add(0,1,32'h2,1, 1,32'h1,1,1);
    add(0,1,32'h3,1, 1,32'h2,1,1);
    add(0,1,32'h4,1, 1,32'h3,1,1);
    add(0,0,32'h0,1, 1,32'h4,1,1);
    add(0,0,32'h0,0, 0,32'h0,1,0);
    // stall fill A,B; C held upstream
    add(0,1,32'hA,0, 0,32'h0,1,0);
    add(0,1,32'hB,0, 1,32'hA,1,1);
    add(0,1,32'hC,0, 1,32'hA,0,2);
    add(0,1,32'hC,1, 1,32'hA,0,2);
    add(0,1,32'hC,1, 1,32'hB,1,1);
    add(0,0,32'h0,1, 1,32'hC,1,1);
    // flush with occupancy 2 and 0xD offered
    add(0,1,32'h10,0, 0,32'h0,1,0);
    add(0,1,32'h11,0, 1,32'h10,1,1);
    add(1,1,32'hD,0,  1,32'h10,0,2);
    add(0,0,32'h0,0,  0,32'h0,1,0);
    // single entry bubble
    add(0,1,32'h5,0, 0,32'h0,1,0);
    add(0,0,32'h0,1, 1,32'h5,1,1);
    add(0,0,32'h0,0, 0,32'h0,1,0);
    // flush while empty refuses input
    add(1,1,32'h7,1, 0,32'h0,0,0);
    add(0,0,32'h0,0, 0,32'h0,1,0);

    fl = 0; iv = 0; ordy = 0; id = '0;
    for (int k = 0; k < 2; k++) begin
      r_fl[k] = 0; r_iv[k] = 0; r_or[k] = 0; r_d[k] = '0;
      mcnt[k] = 0; hold[k] = 0;
    end

    repeat (3) @(negedge clock);
    chk("rst_out_valid", {63'b0, ov}, 64'd0);
    chk("rst_out_data", {32'b0, od}, 64'd0);
    chk("rst_occupancy", {62'b0, occ}, 64'd0);
    chk("rst_in_ready", {63'b0, ir}, 64'd1);
    chk("rst_out_data8", a_od[0], {56'b0, NOP8});
    chk("rst_out_data64", a_od[1], NOP64);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clock);
      fl = vecs[i].fl; iv = vecs[i].iv; id = vecs[i].d; ordy = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d_out_valid", i), {63'b0, ov}, {63'b0, vecs[i].e_ov});
      chk($sformatf("vec%0d_out_data", i), {32'b0, od}, {32'b0, vecs[i].e_od});
      chk($sformatf("vec%0d_in_ready", i), {63'b0, ir}, {63'b0, vecs[i].e_ir});
      chk($sformatf("vec%0d_occupancy", i), {62'b0, occ}, {62'b0, vecs[i].e_occ});
    end

    // async reset mid-stall
    @(negedge clock); fl = 0; iv = 1; id = 32'h21; ordy = 0;
    @(negedge clock); id = 32'h22;
    @(negedge clock); iv = 0;
    #1;
    chk("stall_occupancy", {62'b0, occ}, 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", {63'b0, ov}, 64'd0);
    chk("arst_out_data", {32'b0, od}, 64'd0);
    chk("arst_occupancy", {62'b0, occ}, 64'd0);
    chk("arst_in_ready", {63'b0, ir}, 64'd1);
    @(negedge clock); reset = 1'b1;
    iv = 1; id = 32'h33; ordy = 1;
    @(negedge clock); iv = 0;
    #1;
    chk("post_rst_out_data", {32'b0, od}, 64'h33);
    chk("post_rst_occupancy", {62'b0, occ}, 64'd1);
    @(negedge clock);
    ordy = 0;

    // random back-pressure against the FIFO model
    reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        if (!hold[k]) begin
          r_iv[k] = ($urandom % 4) != 0;
          r_d[k]  = {$urandom, $urandom} & (k == 0 ? 64'hFF : 64'hFFFF_FFFF_FFFF_FFFF);
        end
        r_fl[k] = ($urandom % 32) == 0;
        r_or[k] = ($urandom % 3) != 0;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        logic        e_ir, infire, outfire;
        logic [63:0] e_od;
        e_ir    = !r_fl[k] && (mcnt[k] < 2);
        e_od    = (mcnt[k] > 0) ? mdat[k][0] : (k == 0 ? {56'b0, NOP8} : NOP64);
        chk($sformatf("rnd%0d_c%0d_out_valid", k, c), {63'b0, a_ov[k]}, {63'b0, mcnt[k] > 0});
        chk($sformatf("rnd%0d_c%0d_out_data", k, c), a_od[k], e_od);
        chk($sformatf("rnd%0d_c%0d_occupancy", k, c), {62'b0, a_occ[k]}, 64'(mcnt[k]));
        chk($sformatf("rnd%0d_c%0d_in_ready", k, c), {63'b0, a_ir[k]}, {63'b0, e_ir});
        infire  = r_iv[k] && e_ir;
        outfire = (mcnt[k] > 0) && r_or[k];
        if (r_fl[k]) begin
          mcnt[k] = 0;
        end else begin
          if (outfire) begin
            mdat[k][0] = mdat[k][1];
            mcnt[k]--;
          end
          if (infire) begin
            mdat[k][mcnt[k]] = r_d[k];
            mcnt[k]++;
          end
        end
        hold[k] = r_iv[k] && !infire;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
